io_bus_arbiter: RTL and testbench

// Shares the single 8-bit-address IO bus between two masters: m0 (the MMU IO port) and m1 (the

---
 rtl/io_bus_arbiter.sv | 171 +++++++++++++++++
 tb/tb_io_bus_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : io_bus_arbiter
//  Description : Two-master arbiter for the 8-bit-address IO bus. Serialises
//                m0 (MMU IO port) and m1 (debug/DMA port) requests, drives
//                the bus from registers, tolerates slave wait states up to a
//                bounded timeout and returns a one-cycle ack with read data
//                or an error flag to the granted master.
//  Revision    : 1.0 - initial release
// ============================================================================
module io_bus_arbiter #(
    parameter int FAIR    = 1,   // 1: round-robin on ties, 0: m0 always wins
    parameter int TIMEOUT = 16   // WAIT cycles tolerated with io_ready low (1..255)
) (
    input  logic        clk,
    input  logic        reset,
    // master 0 (MMU IO port)
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [7:0]  m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rdata,
    // master 1 (debug/DMA port)
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [7:0]  m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rdata,
    // IO bus
    output logic        io_en,
    output logic        io_we,
    output logic [7:0]  io_addr,
    output logic [31:0] io_data_write,
    input  logic [31:0] io_data_read,
    input  logic        io_ready
);

    // Bus phase encoding
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUS  = 2'd1;
    localparam logic [1:0] c_ST_WAIT = 2'd2;
    localparam logic [1:0] c_ST_ACK  = 2'd3;

    localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT);
    localparam logic       c_FAIR    = (FAIR != 0);

    logic [1:0]  r_state;
    logic        r_gnt;      // master owning the current transaction (1 = m1)
    logic        r_last;     // master granted most recently (1 = m1)
    logic [7:0]  r_cnt;      // WAIT cycles spent so far in this transaction

    logic        w_any_req;
    logic        w_pick_m1;
    logic        w_finish;
    logic        w_err;
    logic [31:0] w_rdata;

    // Arbitration: a lone requester wins; on a tie FAIR alternates, else m0 wins
    always_comb begin
        w_any_req = m0_req | m1_req;
        w_pick_m1 = 1'b0;
        if (m1_req && !m0_req) begin
            w_pick_m1 = 1'b1;
        end else if (m1_req && m0_req && c_FAIR) begin
            w_pick_m1 = ~r_last;
        end
    end

    // Completion decode: slave ready wins over a simultaneous timeout
    always_comb begin
        w_finish = 1'b0;
        w_err    = 1'b0;
        case (r_state)
            c_ST_BUS: begin
                w_finish = io_ready;
            end
            c_ST_WAIT: begin
                if (io_ready) begin
                    w_finish = 1'b1;
                end else if (r_cnt == c_TIMEOUT) begin
                    w_finish = 1'b1;
                    w_err    = 1'b1;
                end
            end
            default: begin
                w_finish = 1'b0;
            end
        endcase
        // Writes and timeouts return zero data
        w_rdata = (io_ready && !io_we) ? io_data_read : 32'd0;
    end

    // Transaction sequencer with registered bus and ack outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_ST_IDLE;
            r_gnt         <= 1'b0;
            r_last        <= 1'b1;   // so m0 wins the first tie
            r_cnt         <= 8'd0;
            io_en         <= 1'b0;
            io_we         <= 1'b0;
            io_addr       <= 8'd0;
            io_data_write <= 32'd0;
            m0_ack        <= 1'b0;
            m0_err        <= 1'b0;
            m0_rdata      <= 32'd0;
            m1_ack        <= 1'b0;
            m1_err        <= 1'b0;
            m1_rdata      <= 32'd0;
        end else begin
            // Ack, err and rdata are single-cycle pulses
            m0_ack   <= 1'b0;
            m0_err   <= 1'b0;
            m0_rdata <= 32'd0;
            m1_ack   <= 1'b0;
            m1_err   <= 1'b0;
            m1_rdata <= 32'd0;

            case (r_state)
                c_ST_IDLE: begin
                    if (w_any_req) begin
                        r_gnt   <= w_pick_m1;
                        io_en   <= 1'b1;
                        io_we   <= w_pick_m1 ? m1_we    : m0_we;
                        io_addr <= w_pick_m1 ? m1_addr  : m0_addr;
                        io_data_write <= w_pick_m1 ? m1_wdata : m0_wdata;
                        r_state <= c_ST_BUS;
                    end
                end

                c_ST_BUS, c_ST_WAIT: begin
                    if (w_finish) begin
                        io_en   <= 1'b0;
                        io_we   <= 1'b0;
                        r_state <= c_ST_ACK;
                        if (r_gnt) begin
                            m1_ack   <= 1'b1;
                            m1_err   <= w_err;
                            m1_rdata <= w_rdata;
                        end else begin
                            m0_ack   <= 1'b1;
                            m0_err   <= w_err;
                            m0_rdata <= w_rdata;
                        end
                    end else if (r_state == c_ST_BUS) begin
                        r_cnt   <= 8'd1;
                        r_state <= c_ST_WAIT;
                    end else begin
                        r_cnt   <= 8'(r_cnt + 8'd1);
                    end
                end

                c_ST_ACK: begin
                    // Address and write data are left holding; no new grant here
                    r_last  <= r_gnt;
                    r_state <= c_ST_IDLE;
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_io_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_io_bus_arbiter
//  Description : Self-checking bench for io_bus_arbiter. A round-robin
//                (FAIR=1) and a fixed-priority (FAIR=0) instance share the
//                stimulus; both are compared each cycle against a
//                transaction-level model, plus directed tables and sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_io_bus_arbiter;

    localparam int c_TIMEOUT = 16;

    logic        clk;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we, io_ready;
    logic [7:0]  m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata, io_data_read;

    logic        w_f_m0_ack, w_f_m0_err, w_f_m1_ack, w_f_m1_err, w_f_io_en, w_f_io_we;
    logic [31:0] w_f_m0_rdata, w_f_m1_rdata, w_f_io_wd;
    logic [7:0]  w_f_io_addr;
    logic        w_x_m0_ack, w_x_m0_err, w_x_m1_ack, w_x_m1_err, w_x_io_en, w_x_io_we;
    logic [31:0] w_x_m0_rdata, w_x_m1_rdata, w_x_io_wd;
    logic [7:0]  w_x_io_addr;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    io_bus_arbiter #(.FAIR(1), .TIMEOUT(c_TIMEOUT)) u_fair (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(w_f_m0_ack), .m0_err(w_f_m0_err), .m0_rdata(w_f_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(w_f_m1_ack), .m1_err(w_f_m1_err), .m1_rdata(w_f_m1_rdata),
        .io_en(w_f_io_en), .io_we(w_f_io_we), .io_addr(w_f_io_addr),
        .io_data_write(w_f_io_wd), .io_data_read(io_data_read), .io_ready(io_ready)
    );

    io_bus_arbiter #(.FAIR(0), .TIMEOUT(c_TIMEOUT)) u_fixed (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(w_x_m0_ack), .m0_err(w_x_m0_err), .m0_rdata(w_x_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(w_x_m1_ack), .m1_err(w_x_m1_err), .m1_rdata(w_x_m1_rdata),
        .io_en(w_x_io_en), .io_we(w_x_io_we), .io_addr(w_x_io_addr),
        .io_data_write(w_x_io_wd), .io_data_read(io_data_read), .io_ready(io_ready)
    );

    typedef struct packed {
        logic        en;
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wd;
        logic        ack0;
        logic        ack1;
        logic        err0;
        logic        err1;
        logic [31:0] rd0;
        logic [31:0] rd1;
    } outs_t;

    // Reference model: who owns the bus, how many strobe cycles it has had,
    // and who is being acknowledged this cycle.
    int    mdl_owner [2];
    int    mdl_n     [2];
    int    mdl_acking[2];
    bit    mdl_last_m1[2];
    outs_t mdl_out   [2];

    function automatic outs_t snap(input int k);
        outs_t o;
        if (k == 0) begin
            o = '{en: w_f_io_en, we: w_f_io_we, addr: w_f_io_addr, wd: w_f_io_wd,
                  ack0: w_f_m0_ack, ack1: w_f_m1_ack, err0: w_f_m0_err, err1: w_f_m1_err,
                  rd0: w_f_m0_rdata, rd1: w_f_m1_rdata};
        end else begin
            o = '{en: w_x_io_en, we: w_x_io_we, addr: w_x_io_addr, wd: w_x_io_wd,
                  ack0: w_x_m0_ack, ack1: w_x_m1_ack, err0: w_x_m0_err, err1: w_x_m1_err,
                  rd0: w_x_m0_rdata, rd1: w_x_m1_rdata};
        end
        return o;
    endfunction

    // Winner for instance k (0 = round-robin, 1 = fixed priority); -1 if none
    function automatic int pick(input int k);
        if (m0_req && m1_req) return (k == 0) ? (mdl_last_m1[k] ? 0 : 1) : 0;
        if (m0_req) return 0;
        if (m1_req) return 1;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance the model by one clock using the inputs currently applied
    task automatic model_step();
        bit          done, to;
        logic [31:0] rd;
        int          w;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                mdl_owner[k]   = -1;
                mdl_n[k]       = 0;
                mdl_acking[k]  = -1;
                mdl_last_m1[k] = 1'b1;
                mdl_out[k]     = '0;
            end else begin
                mdl_out[k].ack0 = 1'b0;
                mdl_out[k].ack1 = 1'b0;
                mdl_out[k].err0 = 1'b0;
                mdl_out[k].err1 = 1'b0;
                mdl_out[k].rd0  = 32'd0;
                mdl_out[k].rd1  = 32'd0;
                if (mdl_acking[k] >= 0) begin
                    mdl_last_m1[k] = (mdl_acking[k] == 1);
                    mdl_acking[k]  = -1;
                end else if (mdl_owner[k] >= 0) begin
                    done = 1'b0;
                    to   = 1'b0;
                    // slave gets TIMEOUT+1 strobe cycles in total to respond
                    if (io_ready) done = 1'b1;
                    else if (mdl_n[k] == c_TIMEOUT + 1) begin done = 1'b1; to = 1'b1; end
                    else mdl_n[k]++;
                    if (done) begin
                        rd = (io_ready && !mdl_out[k].we) ? io_data_read : 32'd0;
                        mdl_out[k].en = 1'b0;
                        mdl_out[k].we = 1'b0;
                        if (mdl_owner[k] == 0) begin
                            mdl_out[k].ack0 = 1'b1; mdl_out[k].err0 = to; mdl_out[k].rd0 = rd;
                        end else begin
                            mdl_out[k].ack1 = 1'b1; mdl_out[k].err1 = to; mdl_out[k].rd1 = rd;
                        end
                        mdl_acking[k] = mdl_owner[k];
                        mdl_owner[k]  = -1;
                    end
                end else begin
                    w = pick(k);
                    if (w >= 0) begin
                        mdl_owner[k]    = w;
                        mdl_n[k]        = 1;
                        mdl_out[k].en   = 1'b1;
                        mdl_out[k].we   = (w == 1) ? m1_we    : m0_we;
                        mdl_out[k].addr = (w == 1) ? m1_addr  : m0_addr;
                        mdl_out[k].wd   = (w == 1) ? m1_wdata : m0_wdata;
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        outs_t g, e;
        string nm;
        for (int k = 0; k < 2; k++) begin
            g  = snap(k);
            e  = mdl_out[k];
            nm = (k == 0) ? "fair" : "fixed";
            chk({nm, " ctl{en,we,ack0,ack1,err0,err1}"},
                32'({g.en, g.we, g.ack0, g.ack1, g.err0, g.err1}),
                32'({e.en, e.we, e.ack0, e.ack1, e.err0, e.err1}));
            chk({nm, " m0_rdata"}, g.rd0, e.rd0);
            chk({nm, " m1_rdata"}, g.rd1, e.rd1);
            if (e.en) begin
                chk({nm, " io_addr"}, 32'(g.addr), 32'(e.addr));
                chk({nm, " io_data_write"}, g.wd, e.wd);
            end
        end
    endtask

    // One clock: model consumes current inputs, DUT outputs sampled 1ns after the edge
    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        compare_all();
    endtask

    typedef struct {
        bit          rst, r0, r1, rdy;
        bit          e_en, e_we;
        logic [7:0]  e_addr;
        bit          e_a0, e_a1;
        logic [31:0] e_rd;
    } vec_t;

    vec_t  tbl[11];
    outs_t o;
    int    f_who[$], f_when[$];
    int    x0_cnt, x1_cnt, waited;
    bit    seen, s_err;
    logic [31:0] s_rd;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // rst r0 r1 rdy | en we addr ack0 ack1 rdata
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 8'h00, 0, 0, 32'h0};
        tbl[1]  = '{1, 0, 0, 0, 0, 0, 8'h00, 0, 0, 32'h0};
        tbl[2]  = '{0, 1, 0, 0, 1, 0, 8'h04, 0, 0, 32'h0};
        tbl[3]  = '{0, 1, 0, 1, 0, 0, 8'h00, 1, 0, 32'hDEADBEEF};
        tbl[4]  = '{0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 32'h0};
        tbl[5]  = '{0, 0, 1, 0, 1, 1, 8'h08, 0, 0, 32'h0};
        tbl[6]  = '{0, 0, 1, 0, 1, 1, 8'h08, 0, 0, 32'h0};
        tbl[7]  = '{0, 0, 1, 0, 1, 1, 8'h08, 0, 0, 32'h0};
        tbl[8]  = '{0, 0, 1, 0, 1, 1, 8'h08, 0, 0, 32'h0};
        tbl[9]  = '{0, 0, 1, 1, 0, 0, 8'h00, 0, 1, 32'h0};
        tbl[10] = '{0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 32'h0};

        for (int k = 0; k < 2; k++) begin
            mdl_owner[k] = -1; mdl_n[k] = 0; mdl_acking[k] = -1;
            mdl_last_m1[k] = 1'b1; mdl_out[k] = '0;
        end

        m0_we = 1'b0; m0_addr = 8'h04; m0_wdata = 32'hCAFE0000;
        m1_we = 1'b1; m1_addr = 8'h08; m1_wdata = 32'h12345678;
        io_data_read = 32'hDEADBEEF;
        @(posedge clk);
        #1;

        // Directed table: reset, zero-wait m0 read, m1 write with 3 wait cycles
        for (int i = 0; i < 11; i++) begin
            reset = tbl[i].rst; m0_req = tbl[i].r0; m1_req = tbl[i].r1; io_ready = tbl[i].rdy;
            step();
            o = snap(0);
            chk($sformatf("tbl%0d io_en", i), 32'(o.en), 32'(tbl[i].e_en));
            chk($sformatf("tbl%0d io_we", i), 32'(o.we), 32'(tbl[i].e_we));
            if (tbl[i].e_en) chk($sformatf("tbl%0d io_addr", i), 32'(o.addr), 32'(tbl[i].e_addr));
            chk($sformatf("tbl%0d acks", i), 32'({o.ack0, o.ack1}), 32'({tbl[i].e_a0, tbl[i].e_a1}));
            chk($sformatf("tbl%0d m0_rdata", i), o.rd0, tbl[i].e_a0 ? tbl[i].e_rd : 32'd0);
            chk($sformatf("tbl%0d m1_rdata", i), o.rd1, tbl[i].e_a1 ? tbl[i].e_rd : 32'd0);
        end

        // Reset for two cycles while m0 sits in WAIT: no ack, everything cleared
        m0_req = 1'b1; io_ready = 1'b0;
        step(); step(); step();
        reset = 1'b1; m0_req = 1'b0;
        step();
        for (int k = 0; k < 2; k++) begin
            o = snap(k);
            chk("reset ctl", 32'({o.en, o.we, o.ack0, o.ack1, o.err0, o.err1}), 32'd0);
            chk("reset io_addr", 32'(o.addr), 32'd0);
            chk("reset io_data_write", o.wd, 32'd0);
            chk("reset rdata", o.rd0 | o.rd1, 32'd0);
        end
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            o = snap(0);
            chk("post-reset quiet", 32'({o.en, o.ack0, o.ack1}), 32'd0);
        end

        // Both masters requesting continuously for 12 cycles, zero-wait slave
        m0_req = 1'b1; m1_req = 1'b1; io_ready = 1'b1; io_data_read = 32'h11111111;
        x0_cnt = 0; x1_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (w_f_m0_ack) begin f_who.push_back(0); f_when.push_back(cyc); end
            if (w_f_m1_ack) begin f_who.push_back(1); f_when.push_back(cyc); end
            if (w_x_m0_ack) x0_cnt++;
            if (w_x_m1_ack) x1_cnt++;
        end
        m0_req = 1'b0; m1_req = 1'b0;
        chk("fair ack count", 32'(f_who.size()), 32'd4);
        for (int i = 0; i < f_who.size(); i++) begin
            chk($sformatf("fair grant %0d", i), 32'(f_who[i]), 32'(i % 2));
            if (i > 0) chk($sformatf("fair spacing %0d", i), 32'(f_when[i] - f_when[i-1]), 32'd3);
        end
        chk("fixed m0 acks", 32'(x0_cnt), 32'd4);
        chk("fixed m1 acks", 32'(x1_cnt), 32'd0);
        step(); step(); step();

        // Slave stuck low: timeout after 16 WAIT cycles
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 8'h10; io_ready = 1'b0;
        step();
        waited = 0; seen = 1'b0; s_err = 1'b0; s_rd = 32'hFFFFFFFF;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            waited++;
            if (w_f_m0_ack) begin seen = 1'b1; s_err = w_f_m0_err; s_rd = w_f_m0_rdata; end
        end
        chk("timeout ack seen", 32'(seen), 32'd1);
        chk("timeout latency", 32'(waited), 32'd17);
        chk("timeout err", 32'(s_err), 32'd1);
        chk("timeout rdata", s_rd, 32'd0);
        m0_req = 1'b0;
        step();

        // Slave answers exactly in the timeout cycle: success wins
        m0_req = 1'b1;
        step();
        for (int i = 0; i < 16; i++) step();
        io_ready = 1'b1; io_data_read = 32'hA5A50F0F;
        step();
        chk("edge ack", 32'(w_f_m0_ack), 32'd1);
        chk("edge err", 32'(w_f_m0_err), 32'd0);
        chk("edge rdata", w_f_m0_rdata, 32'hA5A50F0F);
        m0_req = 1'b0; io_ready = 1'b0;
        step();

        // m0 drops req and changes address after grant
        m0_req = 1'b1; m0_addr = 8'h04;
        step();
        m0_req = 1'b0; m0_addr = 8'h77;
        step();
        chk("latched addr a", 32'(w_f_io_addr), 32'h04);
        step();
        chk("latched addr b", 32'(w_f_io_addr), 32'h04);
        io_ready = 1'b1;
        step();
        chk("dropped-req ack", 32'(w_f_m0_ack), 32'd1);
        io_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("no spurious txn", 32'({w_f_io_en, w_f_m0_ack, w_f_m1_ack}), 32'd0);
        end

        // Random traffic against the model, with a slow-slave window for timeouts
        for (int i = 0; i < 500; i++) begin
            reset        = ($urandom_range(0, 63) == 0);
            m0_req       = $urandom_range(0, 1) == 1;
            m1_req       = $urandom_range(0, 1) == 1;
            m0_we        = $urandom_range(0, 1) == 1;
            m1_we        = $urandom_range(0, 1) == 1;
            m0_addr      = 8'($urandom);
            m1_addr      = 8'($urandom);
            m0_wdata     = $urandom;
            m1_wdata     = $urandom;
            io_data_read = $urandom;
            if (i >= 250 && i < 350) io_ready = ($urandom_range(0, 31) == 0);
            else                     io_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
